// File: rtl/div_pkg.sv
// Shared types and helpers for the parametrised iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest operand the negate helper handles; callers zero-extend and truncate.
  localparam int DIV_MAX_W = 256;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] v,
                                                    input logic en);
    return en ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_param_if.sv
// Request/result bundle between the issue queue, the divider and ROB writeback.
interface div_unit_param_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 6
) ();

  logic             valid_in;
  logic             ready_out;
  logic             signed_div;
  logic             rem_sel;
  logic [TAG_W-1:0] tag_in;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             valid_out;
  logic             yumi_in;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] tag_out;
  logic             div_by_zero;

  modport master (
    output valid_in, signed_div, rem_sel, tag_in, dividend, divisor, flush, yumi_in,
    input  ready_out, valid_out, result, tag_out, div_by_zero
  );

  modport slave (
    input  valid_in, signed_div, rem_sel, tag_in, dividend, divisor, flush, yumi_in,
    output ready_out, valid_out, result, tag_out, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   pr,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] sor,
  output logic [WIDTH:0]   pr_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted = {pr, bit_in};
    diff    = shifted[WIDTH:0] - {1'b0, sor};
    // A carry out of the shift already means the divisor fits.
    q_bit   = shifted[WIDTH+1] | ~diff[WIDTH];
    pr_next = q_bit ? diff : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_unit_param.sv
// Iterative integer divider, one op in flight, quotient or remainder with ROB tag.
// Build option: define DIV_EARLY_OUT_EN to short-circuit |dividend| < |divisor|.
//
// state | meaning
// IDLE  | ready_out high, waiting for a request
// BUSY  | one restoring step per cycle, WIDTH steps
// FIX   | sign correction and result select
// DONE  | result held; valid_out high from the second cycle until yumi_in
module div_unit_param
  import div_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 6
) (
  input logic              clk,
  input logic              reset,
  div_unit_param_if.slave  io
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] end_q;
  logic [WIDTH-1:0] sor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_end_q;
  logic             sign_sor_q;
  logic             signed_q;
  logic             rem_sel_q;
  logic [WIDTH-1:0] result_q;
  logic [TAG_W-1:0] tag_q;
  logic             dbz_q;
  logic             valid_q;

  logic             accept;
  logic             is_zero;
  logic             is_ovf;
  logic             early_out;
  logic             fast;
  logic [WIDTH-1:0] mag_end;
  logic [WIDTH-1:0] mag_sor;
  logic [WIDTH-1:0] fast_result;
  logic [WIDTH:0]   step_pr;
  logic             step_q;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign accept  = io.valid_in & (state_q == IDLE) & ~io.flush;
  assign is_zero = (io.divisor == '0);
  assign is_ovf  = io.signed_div & (io.dividend == MIN_VAL) & (io.divisor == '1);

  assign mag_end = WIDTH'(cond_neg(DIV_MAX_W'(io.dividend), io.signed_div & io.dividend[WIDTH-1]));
  assign mag_sor = WIDTH'(cond_neg(DIV_MAX_W'(io.divisor), io.signed_div & io.divisor[WIDTH-1]));

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (mag_end < mag_sor);
`else
  assign early_out = 1'b0;
`endif

  assign fast = is_zero | is_ovf | early_out;

  always_comb begin
    fast_result = '0;
    if (is_zero) begin
      fast_result = io.rem_sel ? io.dividend : '1;
    end else if (is_ovf) begin
      fast_result = io.rem_sel ? '0 : MIN_VAL;
    end else begin
      fast_result = io.rem_sel ? io.dividend : '0;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr      (rem_q),
    .bit_in  (end_q[WIDTH-1]),
    .sor     (sor_q),
    .pr_next (step_pr),
    .q_bit   (step_q)
  );

  // After WIDTH steps end_q holds the quotient magnitude, rem_q the remainder magnitude.
  assign quo_fix = WIDTH'(cond_neg(DIV_MAX_W'(end_q), signed_q & (sign_end_q ^ sign_sor_q)));
  assign rem_fix = WIDTH'(cond_neg(DIV_MAX_W'(rem_q[WIDTH-1:0]), signed_q & sign_end_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = fast ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (io.flush) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = io.flush ? IDLE : DONE;
      end
      DONE: begin
        if (io.flush || (valid_q && io.yumi_in)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q      <= '0;
      end_q      <= '0;
      sor_q      <= '0;
      cnt_q      <= '0;
      sign_end_q <= 1'b0;
      sign_sor_q <= 1'b0;
      signed_q   <= 1'b0;
      rem_sel_q  <= 1'b0;
      result_q   <= '0;
      tag_q      <= '0;
      dbz_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      // valid follows DONE one edge late so yumi_in is only honoured once visible.
      valid_q <= (state_q == DONE) && (state_d == DONE);
      if (accept) begin
        rem_q      <= '0;
        end_q      <= mag_end;
        sor_q      <= mag_sor;
        cnt_q      <= CNT_W'(WIDTH);
        sign_end_q <= io.dividend[WIDTH-1];
        sign_sor_q <= io.divisor[WIDTH-1];
        signed_q   <= io.signed_div;
        rem_sel_q  <= io.rem_sel;
        tag_q      <= io.tag_in;
        dbz_q      <= is_zero;
        if (fast) begin
          result_q <= fast_result;
        end
      end else if (state_q == BUSY) begin
        rem_q <= step_pr;
        end_q <= {end_q[WIDTH-2:0], step_q};
        cnt_q <= cnt_q - CNT_W'(1);
      end else if ((state_q == FIX) && !io.flush) begin
        result_q <= rem_sel_q ? rem_fix : quo_fix;
      end
    end
  end

  assign io.ready_out   = (state_q == IDLE);
  assign io.valid_out   = valid_q;
  assign io.result      = result_q;
  assign io.tag_out     = tag_q;
  assign io.div_by_zero = dbz_q;

endmodule
